load_store_unit: RTL and testbench

- Initiator-side adapter between the CPU memory stage and the byte-addressed data memory.
- The data memory has a 1-cycle registered read, word-wide write and a ren/wren strobe pair.
- Accepts byte/half/word loads and stores over a valid/ready request port and returns a single-cycle response pulse.
- Performs lane extraction, sign/zero extension and read-modify-write for sub-word stores; rejects misaligned or out-of-range accesses.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store adapter between the CPU memory stage and a word-wide, 1-cycle-read data memory.
// Optional macro LSU_FAST_LOAD_EN returns load data combinationally in RDATA (load latency N+2).
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_mem_ren,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RDATA, S_WR, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;

  always_comb begin
    req_err = 1'b0;
    case (i_req_size)
      2'b11:   req_err = 1'b1;
      2'b01:   req_err = i_req_addr[0];
      2'b10:   req_err = |i_req_addr[1:0];
      default: req_err = 1'b0;
    endcase
    if ({i_req_addr[31:2], 2'b00} >= MEM_BYTES) req_err = 1'b1;
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = i_mem_rdata[7:0];
      2'd1:    lane_b = i_mem_rdata[15:8];
      2'd2:    lane_b = i_mem_rdata[23:16];
      default: lane_b = i_mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_ext = i_mem_rdata;
    endcase
  end

  // mem_wdata_q carries the latched store value until RDATA overwrites it with the merged word
  always_comb begin
    merged = i_mem_rdata;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = mem_wdata_q[7:0];
        2'd1:    merged[15:8]  = mem_wdata_q[7:0];
        2'd2:    merged[23:16] = mem_wdata_q[7:0];
        default: merged[31:24] = mem_wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = mem_wdata_q[15:0];
    end else begin
      merged[15:0] = mem_wdata_q[15:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          addr_d      = i_req_addr;
          size_d      = i_req_size;
          we_d        = i_req_we;
          uns_d       = i_req_unsigned;
          mem_wdata_d = i_req_wdata;
          rdata_d     = '0;
          err_d       = req_err;
          if (req_err)                              state_d = S_RESP;
          else if (i_req_we && i_req_size == 2'b10) state_d = S_WR;
          else                                      state_d = S_RD;
        end
      end
      S_RD:    state_d = S_RDATA;
      S_RDATA: begin
        if (we_q) begin
          mem_wdata_d = merged;
          state_d     = S_WR;
        end else begin
          rdata_d = load_ext;
`ifdef LSU_FAST_LOAD_EN
          state_d = S_IDLE;
`else
          state_d = S_RESP;
`endif
        end
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_mem_ren   = (state_q == S_RD);
  assign o_mem_wren  = (state_q == S_WR);
  assign o_mem_addr  = (o_mem_ren || o_mem_wren) ? {addr_q[31:2], 2'b00} : '0;
  assign o_mem_wdata = o_mem_wren ? mem_wdata_q : '0;
  assign o_rsp_err   = err_q;

`ifdef LSU_FAST_LOAD_EN
  assign o_rsp_valid = (state_q == S_RESP) || (state_q == S_RDATA && !we_q);
  assign o_rsp_rdata = (state_q == S_RDATA && !we_q) ? load_ext : rdata_q;
`else
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: memory model plus a word-array reference of the addressed memory.
module tb_load_store_unit;
  localparam int unsigned MEM_BYTES = 512;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = '0;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_mem_ren;
  logic        o_mem_wren;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_ren(o_mem_ren), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  always @(posedge clk) begin
    if (o_mem_ren)  i_mem_rdata <= mem[o_mem_addr[8:2]];
    if (o_mem_wren) mem[o_mem_addr[8:2]] <= o_mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    if (size == 2'b01 && addr % 2 != 0) return 1'b1;
    if (size == 2'b10 && addr % 4 != 0) return 1'b1;
    return (addr / 4) * 4 >= MEM_BYTES;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                           input bit uns, input logic [31:0] addr);
    logic [31:0] v;
    int unsigned sh;
    if (size == 2'b10) return w;
    if (size == 2'b00) begin
      sh = (addr % 4) * 8;
      v  = (w >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else begin
      sh = ((addr / 2) % 2) * 16;
      v  = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    int unsigned sh;
    if (size == 2'b10) return wdata;
    if (size == 2'b00) begin
      sh   = (addr % 4) * 8;
      mask = 32'hFF << sh;
    end else begin
      sh   = ((addr / 2) % 2) * 16;
      mask = 32'hFFFF << sh;
    end
    return (w & ~mask) | ((wdata << sh) & mask);
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after the response.
  task automatic do_req(input string tag, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bit          e_err;
    int          e_lat, lat, ren_n, wren_n, e_ren, e_wren;
    logic [31:0] old_w, e_rd, e_new, held;
    int unsigned widx;
    bit          got;
    e_err = ref_err(size, addr);
    widx  = (addr / 4) % WORDS;
    old_w = ref_mem[widx];
    e_rd  = (!e_err && !we) ? ref_load(old_w, size, uns, addr) : 32'h0;
    e_new = ref_store(old_w, size, addr, wdata);
    if (e_err)                        e_lat = 1;
    else if (we && size == 2'b10)     e_lat = 2;
    else if (we)                      e_lat = 4;
`ifdef LSU_FAST_LOAD_EN
    else                              e_lat = 2;
`else
    else                              e_lat = 3;
`endif
    e_ren  = (e_err || (we && size == 2'b10)) ? 0 : 1;
    e_wren = (!e_err && we) ? 1 : 0;

    check($sformatf("%s_ready", tag), {31'b0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wdata;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0; i_req_we = 1'($urandom); i_req_size = 2'($urandom);
    i_req_unsigned = 1'($urandom); i_req_addr = $urandom; i_req_wdata = $urandom;
    lat = 0; ren_n = 0; wren_n = 0; got = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (o_mem_ren) begin
        ren_n++;
        check($sformatf("%s_raddr", tag), o_mem_addr, (addr / 4) * 4);
      end
      if (o_mem_wren) begin
        wren_n++;
        check($sformatf("%s_waddr", tag), o_mem_addr, (addr / 4) * 4);
        check($sformatf("%s_wdata", tag), o_mem_wdata, e_new);
      end
      if (o_rsp_valid) got = 1'b1;
    end
    check($sformatf("%s_lat", tag), lat, e_lat);
    check($sformatf("%s_err", tag), {31'b0, o_rsp_err}, {31'b0, e_err});
    check($sformatf("%s_rdata", tag), o_rsp_rdata, e_rd);
    check($sformatf("%s_ren_n", tag), ren_n, e_ren);
    check($sformatf("%s_wren_n", tag), wren_n, e_wren);
    held = o_rsp_rdata;
    if (e_wren == 1) ref_mem[widx] = e_new;
    @(negedge clk);
    check($sformatf("%s_pulse", tag), {31'b0, o_rsp_valid}, 32'd0);
    check($sformatf("%s_hold", tag), o_rsp_rdata, e_rd);
    if (held !== e_rd) check($sformatf("%s_held", tag), held, e_rd);
  endtask

  task automatic put_word(input int unsigned byte_addr, input logic [31:0] v);
    mem[byte_addr / 4]     = v;
    ref_mem[byte_addr / 4] = v;
  endtask

  initial begin
    for (int i = 0; i < int'(WORDS); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    #12;
    check("rst_ready", {31'b0, o_req_ready}, 32'd1);
    check("rst_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("rst_rdata", o_rsp_rdata, 32'd0);
    check("rst_err", {31'b0, o_rsp_err}, 32'd0);
    check("rst_strobes", {30'b0, o_mem_ren, o_mem_wren}, 32'd0);
    check("rst_maddr", o_mem_addr, 32'd0);
    check("rst_mwdata", o_mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw10_const", o_rsp_rdata, 32'hDEADBEEF);

    put_word(32'h20, 32'h80FF7F01);
    do_req("lb22", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0);
    check("lb22_const", o_rsp_rdata, 32'hFFFFFFFF);
    do_req("lbu23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
    check("lbu23_const", o_rsp_rdata, 32'h00000080);
    do_req("lh20", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
    check("lh20_const", o_rsp_rdata, 32'h00007F01);
    do_req("lhu22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    check("lhu22_const", o_rsp_rdata, 32'h000080FF);

    put_word(32'h30, 32'h11223344);
    do_req("sb31", 1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFFFFAA);
    check("sb31_mem", mem[12], 32'h1122AA44);
    do_req("sh32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h1234BEEF);
    check("sh32_mem", mem[12], 32'hBEEFAA44);

    do_req("err_w12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    do_req("err_h31", 1'b1, 2'b01, 1'b0, 32'h31, 32'h5555);
    do_req("err_sz3", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    do_req("err_w200", 1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678);
    do_req("ok_w1fc", 1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0);

    // Reset asserted while the sub-word store sits in RDATA
    put_word(32'h40, 32'h55667788);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b00; i_req_addr = 32'h40;
    i_req_wdata = 32'h99;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_ren", {31'b0, o_mem_ren}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rmw_rst_strobes", {30'b0, o_mem_ren, o_mem_wren}, 32'd0);
    check("rmw_rst_ready", {31'b0, o_req_ready}, 32'd1);
    check("rmw_rst_valid", {31'b0, o_rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rmw_post_wren", {31'b0, o_mem_wren}, 32'd0);
    end
    check("rmw_mem", mem[16], 32'h55667788);

    for (int t = 0; t < 300; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES + 15));
      do_req($sformatf("rnd%0d", t), 1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    for (int i = 0; i < int'(WORDS); i++)
      if (mem[i] !== ref_mem[i]) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
